// File: rtl/seq_trojan_pkg.sv
// Shared types and helpers for the parametrised sequential-trigger Trojan.
// Provides the trigger FSM state enum, payload mode constants and the log-class encoder.
package seq_trojan_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    FIRE  = 1'b1
  } state_e;

  localparam int MODE_SUBST  = 0;
  localparam int MODE_INVERT = 1;

  // Log-class code of a magnitude: 0 for zero, 1 for 1..3,
  // otherwise the index of the most significant set bit.
  function automatic int unsigned log_class(input logic [31:0] v);
    int unsigned r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if (v[k]) r = k;
    end
    if (v == 32'd0) begin
      r = 0;
    end else if (v < 32'd4) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/trig_fsm.sv
// Hidden trigger: counts qualified falling edges of sample bit 0 and fires a payload window.
// Ports: c, rst (sync, active-high), iv, i0 (sample bit 0) -> trig (FIRE state), cnt (edge count).
import seq_trojan_pkg::*;

module trig_fsm #(
  parameter int CW       = 4,
  parameter int TRIG_CNT = 2,
  parameter int PAY_LEN  = 1,
  parameter int STICKY   = 0
) (
  input  logic          c,
  input  logic          rst,
  input  logic          iv,
  input  logic          i0,
  output logic          trig,
  output logic [CW-1:0] cnt
);

  localparam int PW = $clog2(PAY_LEN + 1);

  state_e          st_q;
  state_e          st_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [PW-1:0]   pay_q;
  logic [PW-1:0]   pay_d;
  logic            prev_q;
  logic            prev_d;
  logic            fe;

  always_ff @(posedge c) begin
    if (rst) begin
      st_q   <= COUNT;
      cnt_q  <= '0;
      pay_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      pay_q  <= pay_d;
      prev_q <= prev_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    pay_d  = pay_q;
    prev_d = prev_q;
    // Only valid samples advance the edge detector.
    fe     = iv & prev_q & ~i0;
    if (iv) prev_d = i0;
    unique case (st_q)
      COUNT: begin
        if (fe) begin
          if (32'(cnt_q) + 32'd1 == 32'(TRIG_CNT)) begin
            st_d  = FIRE;
            cnt_d = '0;
            pay_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIRE: begin
        // One payload is spent per valid sample, not per clock.
        if (iv) begin
          pay_d = pay_q + 1'b1;
          if ((STICKY == 0) &&
              (32'(pay_q) + 32'd1 == 32'(PAY_LEN))) begin
            st_d = COUNT;
          end
        end
      end
      default: st_d = COUNT;
    endcase
  end

  assign trig = (st_q == FIRE);
  assign cnt  = cnt_q;

endmodule

// File: rtl/seq_trojan_param.sv
// Golden path: log-class encode, register, compare against a loaded reference.
// Ports: c, rst, i/iv sample, ld/ld_val reference load -> res/res_v match, trig, cnt.
import seq_trojan_pkg::*;

module seq_trojan_param #(
  parameter int IW       = 10,
  parameter int EW       = $clog2(IW),
  parameter int CW       = 4,
  parameter int TRIG_CNT = 2,
  parameter int PAY_LEN  = 1,
  parameter int STICKY   = 0,
  parameter int MODE     = 0
) (
  input  logic          c,
  input  logic          rst,
  input  logic [IW-1:0] i,
  input  logic          iv,
  input  logic          ld,
  input  logic [EW-1:0] ld_val,
  output logic          res,
  output logic          res_v,
  output logic          trig,
  output logic [CW-1:0] cnt
);

  logic [EW-1:0] ref_q;
  logic [EW-1:0] q;
  logic [EW-1:0] code;
  logic [EW-1:0] pay;
  logic          iv_d1;

  assign code = EW'(log_class(32'(i)));

  // Payload is built from the reference held before this edge.
  assign pay = (MODE == MODE_INVERT) ? (ref_q ^ EW'(1)) : ref_q;

  trig_fsm #(
    .CW       (CW),
    .TRIG_CNT (TRIG_CNT),
    .PAY_LEN  (PAY_LEN),
    .STICKY   (STICKY)
  ) u_trig (
    .c    (c),
    .rst  (rst),
    .iv   (iv),
    .i0   (i[0]),
    .trig (trig),
    .cnt  (cnt)
  );

  always_ff @(posedge c) begin
    if (rst) begin
      ref_q <= '0;
      q     <= '0;
      iv_d1 <= 1'b0;
      res   <= 1'b0;
      res_v <= 1'b0;
    end else begin
      if (ld) ref_q <= ld_val;
      if (iv) q <= trig ? pay : code;
      iv_d1 <= iv;
      res_v <= iv_d1;
      // res holds between valid results.
      if (iv_d1) res <= (q == ref_q);
    end
  end

endmodule

// File: tb/tb_seq_trojan_param.sv
// Self-checking bench: two configurations (substitute/bounded, invert/sticky)
// against a behavioural model, directed steps followed by random traffic.
module tb_seq_trojan_param;

  logic       c;
  logic       rst;
  logic [9:0] i;
  logic       iv;
  logic       ld;
  logic [3:0] ld_val;

  logic       res_o  [2];
  logic       resv_o [2];
  logic       trig_o [2];
  logic [3:0] cnt_o  [2];

  int tests;
  int fails;

  int P_MODE   [2] = '{0, 1};
  int P_STICKY [2] = '{0, 1};
  int P_PAY    [2] = '{1, 1};
  int P_TRIG   [2] = '{2, 2};

  int m_ref   [2];
  int m_prev  [2];
  int m_edges [2];
  int m_left  [2];
  int m_q     [2];
  int m_res   [2];
  int m_resv  [2];
  int m_pend  [2];

  seq_trojan_param #(
    .IW(10), .CW(4), .TRIG_CNT(2), .PAY_LEN(1), .STICKY(0), .MODE(0)
  ) u0 (
    .c(c), .rst(rst), .i(i), .iv(iv), .ld(ld), .ld_val(ld_val),
    .res(res_o[0]), .res_v(resv_o[0]), .trig(trig_o[0]), .cnt(cnt_o[0])
  );

  seq_trojan_param #(
    .IW(10), .CW(4), .TRIG_CNT(2), .PAY_LEN(1), .STICKY(1), .MODE(1)
  ) u1 (
    .c(c), .rst(rst), .i(i), .iv(iv), .ld(ld), .ld_val(ld_val),
    .res(res_o[1]), .res_v(resv_o[1]), .trig(trig_o[1]), .cnt(cnt_o[1])
  );

  initial c = 1'b0;
  always #5 c = ~c;

  function automatic int enc(input int x);
    int r;
    if (x == 0) return 0;
    if (x < 4) return 1;
    r = 0;
    while ((1 << (r + 1)) <= x) r++;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic v, input int x,
                       input logic l, input int lv);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_ref[k] = 0; m_prev[k] = 0; m_edges[k] = 0; m_left[k] = 0;
        m_q[k] = 0; m_res[k] = 0; m_resv[k] = 0; m_pend[k] = 0;
      end else begin
        bit firing;
        firing = (m_left[k] != 0);
        m_resv[k] = m_pend[k];
        if (m_pend[k] != 0) m_res[k] = (m_q[k] == m_ref[k]) ? 1 : 0;
        if (v) begin
          if (firing) begin
            m_q[k] = (P_MODE[k] == 1) ? (m_ref[k] ^ 1) : m_ref[k];
            if (m_left[k] > 0) m_left[k]--;
          end else begin
            m_q[k] = enc(x);
            if (m_prev[k] == 1 && (x % 2) == 0) begin
              m_edges[k]++;
              if (m_edges[k] == P_TRIG[k]) begin
                m_edges[k] = 0;
                m_left[k] = (P_STICKY[k] != 0) ? -1 : P_PAY[k];
              end
            end
          end
          m_prev[k] = x % 2;
        end
        m_pend[k] = v ? 1 : 0;
        if (l) m_ref[k] = lv;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("res[%0d]", k), 32'(res_o[k]), 32'(m_res[k]));
      chk($sformatf("res_v[%0d]", k), 32'(resv_o[k]), 32'(m_resv[k]));
      chk($sformatf("trig[%0d]", k), 32'(trig_o[k]),
          (m_left[k] != 0) ? 32'd1 : 32'd0);
      chk($sformatf("cnt[%0d]", k), 32'(cnt_o[k]), 32'(m_edges[k]));
    end
  endtask

  task automatic step(input logic r, input logic v, input int x,
                      input logic l, input int lv);
    rst = r; iv = v; i = 10'(x); ld = l; ld_val = 4'(lv);
    @(posedge c);
    model(r, v, x, l, lv);
    #1;
    check_all();
  endtask

  int sweep [9] = '{0, 4, 8, 512, 1, 3, 7, 255, 1023};

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; iv = 1'b0; i = '0; ld = 1'b0; ld_val = '0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset res_v", 32'(resv_o[0]), 32'd0);
    chk("reset trig", 32'(trig_o[0]), 32'd0);
    chk("reset cnt", 32'(cnt_o[0]), 32'd0);

    // Encoder sweep, ordered so bit 0 only rises (no trigger activity).
    step(0, 1, sweep[0], 1, enc(sweep[0]));
    for (int n = 1; n < 9; n++) begin
      step(0, 1, sweep[n], 1, enc(sweep[n]));
      chk($sformatf("enc i=%0d", sweep[n-1]), 32'(res_o[0]), 32'd1);
    end
    step(0, 0, 0, 0, 0);
    chk("enc i=1023", 32'(res_o[0]), 32'd1);
    chk("enc 1023 code9", 32'(enc(1023)), 32'd9);

    // Compare against ref=5.
    step(0, 0, 0, 1, 5);
    step(0, 1, 40, 0, 0);
    step(0, 1, 64, 0, 0);
    chk("cmp 40 res", 32'(res_o[0]), 32'd1);
    chk("cmp 40 res_v", 32'(resv_o[0]), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("cmp 64 res", 32'(res_o[0]), 32'd0);
    for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0);
    chk("gap res_v", 32'(resv_o[0]), 32'd0);
    chk("gap res hold", 32'(res_o[0]), 32'd0);

    // Bounded substitute payload, ref=7.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("fire cnt1", 32'(cnt_o[0]), 32'd1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("fire trig", 32'(trig_o[0]), 32'd1);
    step(0, 1, 0, 0, 0);
    chk("fire trig off", 32'(trig_o[0]), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("payload res", 32'(res_o[0]), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("post payload res", 32'(res_o[0]), 32'd0);

    // Sticky invert payload, ref=3.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      step(0, 1, 8, 0, 0);
      if (n > 0) chk("sticky res", 32'(res_o[1]), 32'd0);
      chk("sticky trig", 32'(trig_o[1]), 32'd1);
    end
    step(1, 0, 0, 0, 0);
    chk("sticky rst trig", 32'(trig_o[1]), 32'd0);
    step(0, 0, 0, 1, 3);
    step(0, 1, 8, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("sticky rst res", 32'(res_o[1]), 32'd1);

    // Edges across iv gaps.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("gap cnt0", 32'(cnt_o[0]), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("gap cnt1", 32'(cnt_o[0]), 32'd1);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("iv0 edges", 32'(cnt_o[0]), 32'd1);

    // Reset while firing.
    step(0, 1, 0, 0, 0);
    chk("pre rst trig", 32'(trig_o[0]), 32'd1);
    step(1, 1, 0, 0, 0);
    chk("rst trig", 32'(trig_o[0]), 32'd0);
    chk("rst cnt", 32'(cnt_o[0]), 32'd0);
    chk("rst res_v", 32'(resv_o[0]), 32'd0);

    // Load racing a sample.
    step(0, 1, 600, 1, 9);
    step(0, 0, 0, 0, 0);
    chk("ld race res", 32'(res_o[0]), 32'd1);
    chk("ld race res_v", 32'(resv_o[0]), 32'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic r, v, l;
      int   x, lv;
      r  = ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 3) != 0);
      x  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, 1023));
      l  = ($urandom_range(0, 4) == 0);
      lv = ($urandom_range(0, 1) == 0) ? enc(x)
                                       : int'($urandom_range(0, 15));
      step(r, v, x, l, lv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
